// File: rtl/os_psum_drain_pkg.sv
// Shared defaults, entry layout and round-robin pick helper for the OS psum drain.
package os_psum_drain_pkg;

    localparam int unsigned PSUM_BW    = 16;
    localparam int unsigned ROW        = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned ROW_W      = $clog2(ROW);

    // Upper bound on row count the pick helper can scan.
    localparam int unsigned MAX_ROW   = 64;
    localparam int unsigned MAX_ROW_W = $clog2(MAX_ROW);

    typedef struct packed {
        logic [ROW_W-1:0]   row_idx;
        logic [PSUM_BW-1:0] psum;
    } entry_t;

    // First set bit of pending at or after ptr, wrapping modulo n; 0 when none set.
    function automatic int unsigned rr_pick(input logic [MAX_ROW-1:0] pending,
                                            input int unsigned         ptr,
                                            input int unsigned         n);
        int unsigned idx;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_ROW; i++) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && pending[idx[MAX_ROW_W-1:0]]) begin
                    found   = 1'b1;
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/os_psum_drain_if.sv
// Drain output stream: row-tagged psum with valid/ready handshake.
interface os_psum_drain_if #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned row     = 8
);
    logic [psum_bw-1:0]      out_data;
    logic [$clog2(row)-1:0]  out_row;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_row,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/os_psum_drain_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head that holds its last value when empty.
module os_psum_drain_sync_fifo #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [width-1:0]         push_data,
    input  logic                     pop,
    output logic [width-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);
    localparam int unsigned PtrW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic [width-1:0] head_q, head_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != (PtrW+1)'(depth)) || do_pop);
        rd_d    = do_pop  ? rd_q + PtrW'(1) : rd_q;
        wr_d    = do_push ? wr_q + PtrW'(1) : wr_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (PtrW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (PtrW+1)'(1);
        end
        // New head bypasses the array when it is the entry being written this edge.
        head_d = head_q;
        if (cnt_d != '0) begin
            head_d = (do_push && (rd_d == wr_q)) ? push_data : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign head  = head_q;
    assign full  = (cnt_q == (PtrW+1)'(depth));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/os_psum_drain.sv
// Per-row psum capture slots, round-robin serializer into a sync FIFO, and sticky overflow flag.
module os_psum_drain
    import os_psum_drain_pkg::*;
#(
    parameter int unsigned psum_bw    = PSUM_BW,
    parameter int unsigned row        = ROW,
    parameter int unsigned fifo_depth = FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [row*psum_bw-1:0]        os_out_in,
    input  logic [row-1:0]                os_valid_in,
    os_psum_drain_if.master               out_if,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy
);
    localparam int unsigned RowW   = $clog2(row);
    localparam int unsigned EntryW = RowW + psum_bw;

    logic [psum_bw-1:0] slot_q [row];
    logic [psum_bw-1:0] slot_d [row];
    logic [row-1:0]     pend_q, pend_d, grant, take, drop;
    logic [RowW-1:0]    rr_q, rr_d, pick_idx;
    logic               ovf_q, ovf_d;
    logic               push, pop, full, empty;
    logic [EntryW-1:0]  push_data, head;

    assign pop = out_if.out_valid && out_if.out_ready;

    always_comb begin
        pick_idx  = RowW'(rr_pick(MAX_ROW'(pend_q), 32'(rr_q), row));
        // A full FIFO still accepts when the consumer pops at the same edge.
        push      = (|pend_q) && (!full || pop);
        grant     = push ? (row'(1) << pick_idx) : '0;
        push_data = {pick_idx, slot_q[pick_idx]};
        rr_d      = rr_q;
        if (push) begin
            rr_d = (pick_idx == RowW'(row - 1)) ? '0 : pick_idx + RowW'(1);
        end
        ovf_d = ovf_q | (|drop);
    end

    // A slot being drained this edge is free for a new capture.
    for (genvar r = 0; r < row; r++) begin : g_row
        assign take[r]   = os_valid_in[r] & (~pend_q[r] | grant[r]);
        assign drop[r]   = os_valid_in[r] & pend_q[r] & ~grant[r];
        assign pend_d[r] = take[r] | (pend_q[r] & ~grant[r]);
        assign slot_d[r] = take[r] ? os_out_in[r*psum_bw +: psum_bw] : slot_q[r];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '{default: '0};
            pend_q <= '0;
            rr_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            slot_q <= slot_d;
            pend_q <= pend_d;
            rr_q   <= rr_d;
            ovf_q  <= ovf_d;
        end
    end

    os_psum_drain_sync_fifo #(
        .width (EntryW),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign out_if.out_data  = head[psum_bw-1:0];
    assign out_if.out_row   = head[EntryW-1:psum_bw];
    assign out_if.out_valid = !empty;
    assign overflow         = ovf_q;
    assign busy             = (|pend_q) || !empty;

endmodule

// File: tb/tb_os_psum_drain.sv
// Directed bench for os_psum_drain: latency, ordering, fairness, back-pressure, overflow, reset.
module tb_os_psum_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] psum_v [8];
    logic [127:0] os_out_in;
    logic [7:0]  os_valid_in = '0;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    os_psum_drain_if #(.psum_bw(16), .row(8)) dut_if ();

    assign os_out_in = {psum_v[7], psum_v[6], psum_v[5], psum_v[4],
                        psum_v[3], psum_v[2], psum_v[1], psum_v[0]};

    os_psum_drain #(
        .psum_bw    (16),
        .row        (8),
        .fifo_depth (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .os_out_in   (os_out_in),
        .os_valid_in (os_valid_in),
        .out_if      (dut_if.master),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] mask);
        os_valid_in = mask;
        tick();
        os_valid_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 8; r++) psum_v[r[2:0]] = '0;
        dut_if.out_ready = 1'b1;
        do_reset();
        check("rst_valid", 32'(dut_if.out_valid), 0);
        check("rst_data", 32'(dut_if.out_data), 0);
        check("rst_row", 32'(dut_if.out_row), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_busy", 32'(busy), 0);

        // Single pulse on row 3.
        psum_v[3] = 16'h0123;
        pulse(8'h08);
        check("t1_valid_e0", 32'(dut_if.out_valid), 0);
        check("t1_busy_e0", 32'(busy), 1);
        tick();
        check("t1_valid", 32'(dut_if.out_valid), 1);
        check("t1_data", 32'(dut_if.out_data), 32'h0123);
        check("t1_row", 32'(dut_if.out_row), 3);
        check("t1_count", 32'(fifo_count), 1);
        tick();
        check("t1_busy_end", 32'(busy), 0);
        check("t1_valid_end", 32'(dut_if.out_valid), 0);
        check("t1_hold", 32'(dut_if.out_data), 32'h0123);

        // All rows together from rr_ptr = 0.
        do_reset();
        for (int r = 0; r < 8; r++) psum_v[r[2:0]] = 16'(r * 16'h11);
        pulse(8'hFF);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t2_valid", 32'(dut_if.out_valid), 1);
            check("t2_row", 32'(dut_if.out_row), 32'(k));
            check("t2_data", 32'(dut_if.out_data), 32'(k * 16'h11));
        end
        check("t2_ovf", 32'(overflow), 0);
        tick();
        check("t2_valid_end", 32'(dut_if.out_valid), 0);
        check("t2_busy_end", 32'(busy), 0);

        // Fairness: row 4 transfer leaves rr_ptr = 5; rows 2 and 6 pending.
        psum_v[4] = 16'h4444;
        pulse(8'h10);
        tick();
        check("t3_row4", 32'(dut_if.out_row), 4);
        psum_v[2] = 16'h2222;
        psum_v[6] = 16'h6666;
        pulse(8'h44);
        check("t3_gap", 32'(dut_if.out_valid), 0);
        tick();
        check("t3_first_row", 32'(dut_if.out_row), 6);
        check("t3_first_data", 32'(dut_if.out_data), 32'h6666);
        tick();
        check("t3_second_row", 32'(dut_if.out_row), 2);
        check("t3_second_data", 32'(dut_if.out_data), 32'h2222);
        tick();
        check("t3_valid_end", 32'(dut_if.out_valid), 0);

        // Back-pressure: 20 pulses, FIFO saturates, slots 0..3 hold the rest.
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            psum_v[i[2:0]] = 16'(16'h100 + i);
            pulse(8'(1) << (i % 8));
        end
        check("t4_count_full", 32'(fifo_count), 16);
        check("t4_ovf_before", 32'(overflow), 0);
        psum_v[0] = 16'h01FF;
        pulse(8'h01);
        check("t4_ovf", 32'(overflow), 1);
        check("t4_count_hold", 32'(fifo_count), 16);
        check("t4_busy", 32'(busy), 1);

        // Drain: full FIFO pushes pending slots on the same edges it pops.
        dut_if.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("t4_valid", 32'(dut_if.out_valid), 1);
            check("t4_data", 32'(dut_if.out_data), 32'(16'h100 + k));
            check("t4_row", 32'(dut_if.out_row), 32'(k % 8));
            tick();
            if (k == 0) check("t5_count_pushpop", 32'(fifo_count), 16);
            if (k == 3) check("t5_count_last_push", 32'(fifo_count), 16);
            if (k == 4) check("t4_count_dec", 32'(fifo_count), 15);
        end
        check("t4_empty", 32'(dut_if.out_valid), 0);
        check("t4_busy_end", 32'(busy), 0);
        check("t4_ovf_sticky", 32'(overflow), 1);

        // Reset with 5 entries queued.
        dut_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            psum_v[i[2:0]] = 16'(16'h500 + i);
            pulse(8'(1) << i);
        end
        tick();
        check("t6_count_pre", 32'(fifo_count), 5);
        do_reset();
        check("t6_valid", 32'(dut_if.out_valid), 0);
        check("t6_count", 32'(fifo_count), 0);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_busy", 32'(busy), 0);
        dut_if.out_ready = 1'b1;
        psum_v[5] = 16'hBEEF;
        pulse(8'h20);
        check("t6_valid_e0", 32'(dut_if.out_valid), 0);
        tick();
        check("t6_valid_post", 32'(dut_if.out_valid), 1);
        check("t6_data_post", 32'(dut_if.out_data), 32'hBEEF);
        check("t6_row_post", 32'(dut_if.out_row), 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
